// File: rtl/cpu_test_sequencer.sv
// Loads a test image into IM/DM, holds the CPU in reset, runs it under a cycle budget, signs writebacks.
// Latency: 1 + im_len + dm_len + RST_CYCLES cycles from start to first RUN cycle; done one cycle after halt/budget.
// Backpressure: src_req/src_kind/src_addr hold steady until src_valid; each accept writes memory on the next cycle.
module cpu_test_sequencer #(
    parameter int          IM_DEPTH   = 1024,
    parameter int          DM_DEPTH   = 1024,
    parameter int          NUM_TESTS  = 4,
    parameter int          CYC_W      = 20,
    parameter int          RST_CYCLES = 4,
    parameter logic [31:0] HALT_PC    = 32'h0000_3ffc
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       test_sel,
    input  logic [15:0]      im_words,
    input  logic [15:0]      dm_words,
    input  logic [CYC_W-1:0] cycle_budget,
    input  logic [31:0]      expected_sig,
    output logic             src_req,
    output logic [3:0]       src_test,
    output logic             src_kind,
    output logic [15:0]      src_addr,
    input  logic [31:0]      src_data,
    input  logic             src_valid,
    output logic             im_we,
    output logic [15:0]      im_addr,
    output logic [31:0]      im_wdata,
    output logic             dm_we,
    output logic [15:0]      dm_addr,
    output logic [31:0]      dm_wdata,
    output logic             cpu_rst,
    input  logic [31:0]      pc_f,
    input  logic             wb_en,
    input  logic [4:0]       wb_reg,
    input  logic [31:0]      wb_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic             error,
    output logic [31:0]      signature,
    output logic [CYC_W-1:0] cycles
);

    typedef enum logic [2:0] {IDLE, LOAD_IM, LOAD_DM, HOLD, RUN, FINISH} state_t;

    localparam logic [16:0]      IM_MAX    = 17'(IM_DEPTH);
    localparam logic [16:0]      DM_MAX    = 17'(DM_DEPTH);
    localparam logic [4:0]       NT        = 5'(NUM_TESTS);
    localparam int               HW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_ONE   = CYC_W'(1);

    state_t             state, state_nxt;
    logic [3:0]         test_q;
    logic [16:0]        im_len_q, dm_len_q, im_len_in, dm_len_in, cur_len;
    logic [15:0]        addr_q;
    logic [HW-1:0]      hold_q;
    logic [CYC_W-1:0]   budget_q, cycles_nxt;
    logic [31:0]        exp_q, sig_nxt;
    logic               sel_ok, accept, last_word, halt_hit, budget_hit;

    always_comb begin
        im_len_in  = ({1'b0, im_words} > IM_MAX) ? IM_MAX : {1'b0, im_words};
        dm_len_in  = ({1'b0, dm_words} > DM_MAX) ? DM_MAX : {1'b0, dm_words};
        sel_ok     = {1'b0, test_sel} < NT;
        src_req    = (state == LOAD_IM) || (state == LOAD_DM);
        src_kind   = (state == LOAD_DM);
        src_addr   = addr_q;
        src_test   = test_q;
        accept     = src_req && src_valid;
        cur_len    = (state == LOAD_DM) ? dm_len_q : im_len_q;
        last_word  = ({1'b0, addr_q} == (cur_len - 17'd1));
        cycles_nxt = cycles + CYC_ONE;
        sig_nxt    = signature;
        if (wb_en && (wb_reg != 5'd0))
            sig_nxt = {signature[30:0], signature[31]} ^ wb_data ^ {27'b0, wb_reg};
        halt_hit   = (pc_f == HALT_PC);
        // A zero budget ends the run after its first cycle.
        budget_hit = (cycles_nxt == budget_q) || (budget_q == '0);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && sel_ok) begin
                    if (im_len_in != 17'd0)      state_nxt = LOAD_IM;
                    else if (dm_len_in != 17'd0) state_nxt = LOAD_DM;
                    else                         state_nxt = HOLD;
                end
            end
            LOAD_IM: if (accept && last_word) state_nxt = (dm_len_q != 17'd0) ? LOAD_DM : HOLD;
            LOAD_DM: if (accept && last_word) state_nxt = HOLD;
            HOLD:    if (hold_q == HOLD_LAST) state_nxt = RUN;
            RUN:     if (halt_hit || budget_hit) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            test_q    <= '0;
            im_len_q  <= '0;
            dm_len_q  <= '0;
            budget_q  <= '0;
            exp_q     <= '0;
            addr_q    <= '0;
            hold_q    <= '0;
            im_we     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= '0;
            dm_we     <= 1'b0;
            dm_addr   <= '0;
            dm_wdata  <= '0;
            cpu_rst   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            error     <= 1'b0;
            signature <= '0;
            cycles    <= '0;
        end else begin
            im_we   <= 1'b0;
            dm_we   <= 1'b0;
            done    <= 1'b0;
            cpu_rst <= (state_nxt != RUN);
            busy    <= (state_nxt == LOAD_IM) || (state_nxt == LOAD_DM) ||
                       (state_nxt == HOLD) || (state_nxt == RUN);
            hold_q  <= (state == HOLD) ? hold_q + 1'b1 : '0;
            if (accept)             addr_q <= addr_q + 16'd1;
            if (state_nxt != state) addr_q <= '0;

            case (state)
                IDLE: begin
                    if (start) begin
                        pass    <= 1'b0;
                        timeout <= 1'b0;
                        if (!sel_ok) begin
                            error <= 1'b1;
                            done  <= 1'b1;
                        end else begin
                            error     <= 1'b0;
                            test_q    <= test_sel;
                            im_len_q  <= im_len_in;
                            dm_len_q  <= dm_len_in;
                            budget_q  <= cycle_budget;
                            exp_q     <= expected_sig;
                            signature <= '0;
                            cycles    <= '0;
                        end
                    end
                end
                LOAD_IM: begin
                    if (accept) begin
                        im_we    <= 1'b1;
                        im_addr  <= addr_q;
                        im_wdata <= src_data;
                    end
                end
                LOAD_DM: begin
                    if (accept) begin
                        dm_we    <= 1'b1;
                        dm_addr  <= addr_q;
                        dm_wdata <= src_data;
                    end
                end
                RUN: begin
                    cycles    <= cycles_nxt;
                    signature <= sig_nxt;
                    // Halt takes priority over the budget when both land together.
                    if (halt_hit || budget_hit) begin
                        done    <= 1'b1;
                        pass    <= halt_hit && (sig_nxt == exp_q);
                        timeout <= !halt_hit;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
